alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares the single-cycle integer ALU between two requesters, such as the execute stage and a branch-compare unit. Each requester has a valid/ready request channel and a valid/ready response channel. The block arbitrates between requesters and registers the winner's operands and opcode. It then drives them into the ALU for exactly one cycle, captures the result and Zero flag, and holds the response until the winner accepts it.

## Interface
- No parameters; the data width is fixed at 32 bits and the opcode width at 4 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req0_valid / req1_valid  input  1  the requester has an operation pending.
- req0_ready / req1_ready  output  1  the request is accepted this cycle; asserted combinationally.
- req0_a, req0_b / req1_a, req1_b  input  32  operands.
- req0_op / req1_op  input  4  ALU opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB/compare; any other code passes A through.
- rsp0_valid / rsp1_valid  output  1  a response is held for that requester.
- rsp0_ready / rsp1_ready  input  1  the requester consumes the response.
- rsp_result  output  32  shared response data; valid only with the matching rspN_valid.
- rsp_zero  output  1  shared Zero flag.
- alu_a, alu_b  output  32  registered operands driven to the ALU.
- alu_control  output  4  registered opcode driven to the ALU.
- alu_result  input  32  ALU result, combinational from alu_a/alu_b/alu_control.
- alu_zero  input  1  ALU Zero flag.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - When no reqN_valid is high, stay in IDLE with both readies low.
  - Otherwise, select a winner and raise only the winner's reqN_ready in the same cycle.
  - On that edge: latch the winner's A, B and op into alu_a/alu_b/alu_control, latch the owner ID, and go to EXEC.
- EXEC: on the edge, capture alu_result and alu_zero into the response registers, then go to RESP.
- Result forcing: when the captured alu_zero=1, rsp_result is forced to 32'h0000_0000. Compare-equal results are therefore always deterministic.
- RESP:
  - rspN_valid is high for the owner only; both reqN_ready are low.
  - When the owner's rspN_ready is high, on the edge: clear rspN_valid, update the last-served pointer to the owner, and go to IDLE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the winner is chosen by the policy in Configuration.
- Request rules:
  - Requests are never dropped. A reqN_valid that is held high is eventually granted.
  - A requester may change its operands while not granted; only the values present on the grant edge are used.
- The non-owner's rspN_ready is ignored.

## Timing
- Accept on edge N, then result captured on edge N+1. rspN_valid rises after edge N+1 and is visible in cycle N+2.
- Minimum of 3 cycles per operation. If rspN_ready is already high when rspN_valid rises, the next grant can occur in the cycle following the response handshake.
- Response backpressure stalls the FSM in RESP indefinitely; the ALU inputs hold their values.
- Reset values, applied asynchronously:
  - state = IDLE;
  - alu_a = alu_b = 0, alu_control = 4'b0000;
  - rsp_result = 0, rsp_zero = 0, rsp0_valid = rsp1_valid = 0;
  - last-served pointer = requester 1, so requester 0 wins first.
- reqN_ready is 0 while rst_n is low.
- Reset mid-operation (in EXEC or RESP) discards the operation; no response is ever issued for it.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration. On a collision, the requester that was not last served wins, and last-served updates on every response handshake.
- ALU_ARB_RR_EN undefined: fixed priority, where req0 always wins a collision. The pointer register is not implemented.

## Test plan
- Single request: req0 ADD A=5, B=7 with rsp0_ready tied high → req0_ready for 1 cycle; rsp0_valid 2 cycles later with rsp_result=12 and rsp_zero=0; rsp1_valid stays 0.
- Compare-equal: req1 op=0110, A=B=32'h1234 → rsp1_valid with rsp_zero=1 and rsp_result=0. Then A=9, B=4 → rsp_result=5, rsp_zero=0.
- Collision after reset: both valid with req0 AND(F0,3C) and req1 OR(F0,3C).
  - With RR: req0 is served first (result 30), then req1 (result FC).
  - Both valid held continuously with RR: grants alternate 0,1,0,1.
  - Without the macro: req0 is always granted.
- Backpressure: hold rsp0_ready=0 for 10 cycles → rsp0_valid, rsp_result and alu_* stay stable, and no reqN_ready is asserted. Releasing rsp0_ready gives exactly one handshake.
- Reset mid-operation: assert rst_n=0 in the EXEC cycle → all outputs go to their reset values immediately; after release, no stale rsp valid appears and the next request completes normally.
- Default opcode: op=4'b1111, A=32'hDEADBEEF → rsp_result=32'hDEADBEEF, rsp_zero=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one single-cycle ALU between two requesters.
// A requester is granted in IDLE. Its operands are registered and driven to
// the ALU for one cycle (EXEC). The result is captured and held in RESP
// until the owner accepts it.
// Optional feature macro: ALU_ARB_RR_EN selects round-robin arbitration.
// Without it, req0 has fixed priority.
//
// state | meaning
// IDLE  | waiting for a request, grant issued combinationally
// EXEC  | registered operands on the ALU, result captured on the edge
// RESP  | response held for the owner until its rsp ready
module alu_share_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [3:0]  r_alu_control;
    logic [31:0] r_rsp_result;
    logic        r_rsp_zero;

    logic        w_any_req;
    logic        w_win1;
    logic        w_owner_rsp_ready;

    assign w_any_req         = req0_valid | req1_valid;
    assign w_owner_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

`ifdef ALU_ARB_RR_EN
    logic r_last;

    // Last-served pointer; reset to requester 1 so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (r_state == S_RESP && w_owner_rsp_ready) begin
            r_last <= r_owner;
        end
    end

    // On a collision, the requester that was not served last wins
    assign w_win1 = req1_valid & (~req0_valid | ~r_last);
`else
    // Fixed priority: requester 1 wins only when requester 0 is idle
    assign w_win1 = req1_valid & ~req0_valid;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_RESP;
            S_RESP:  if (w_owner_rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs; grants are also gated by rst_n so none appear during reset
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = rst_n & req0_valid & ~w_win1;
                req1_ready = rst_n & w_win1;
            end
            S_RESP: begin
                rsp0_valid = ~r_owner;
                rsp1_valid = r_owner;
            end
            default: ;
        endcase
    end

    // Datapath: latch the winner's operands on grant, capture the ALU result in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner       <= 1'b0;
            r_alu_a       <= 32'd0;
            r_alu_b       <= 32'd0;
            r_alu_control <= 4'b0000;
            r_rsp_result  <= 32'd0;
            r_rsp_zero    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_owner       <= w_win1;
                r_alu_a       <= w_win1 ? req1_a  : req0_a;
                r_alu_b       <= w_win1 ? req1_b  : req0_b;
                r_alu_control <= w_win1 ? req1_op : req0_op;
            end
            if (r_state == S_EXEC) begin
                // A zero flag forces a zero result, so compare results are deterministic
                r_rsp_result <= alu_zero ? 32'd0 : alu_result;
                r_rsp_zero   <= alu_zero;
            end
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_control;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Behavioural single-cycle ALU
    always_comb begin
        alu_result = alu_a;
        case (alu_control)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            default: alu_result = alu_a;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Call at posedge+1; returns at posedge+1 just after the grant edge
    task automatic run_req(input int which, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           output bit granted);
        granted = 1'b0;
        if (which == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        for (int i = 0; i < 12 && !granted; i++) begin
            @(negedge clk);
            if ((which == 0 && req0_ready) || (which == 1 && req1_ready)) granted = 1'b1;
            @(posedge clk); #1;
        end
        if (which == 0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    // Returns at the negedge where the response is first visible
    task automatic wait_rsp(input int which, output bit got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((which == 0 && rsp0_valid) || (which == 1 && rsp1_valid)) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++;
            $display("FAIL reset_rsp_valid: got %b%b expected 00", rsp0_valid, rsp1_valid); end
        checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 4'd0) begin errors++;
            $display("FAIL reset_alu: got %h %h %h expected 0 0 0", alu_a, alu_b, alu_control); end
        checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin errors++;
            $display("FAIL reset_rsp: got %h %b expected 0 0", rsp_result, rsp_zero); end
        apply_reset();
    endtask

    task automatic test_single();
        rsp0_ready = 1'b1;
        req0_op = 4'b0010; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL single_grant: got %b%b expected 10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin errors++;
            $display("FAIL single_exec: got ready=%b rsp=%b expected 0 0", req0_ready, rsp0_valid); end
        checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_control !== 4'b0010) begin errors++;
            $display("FAIL single_alu: got %h %h %h expected 5 7 2", alu_a, alu_b, alu_control); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin errors++;
            $display("FAIL single_rsp_valid: got %b%b expected 10", rsp0_valid, rsp1_valid); end
        checks++; if (rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin errors++;
            $display("FAIL single_rsp: got %h %b expected c 0", rsp_result, rsp_zero); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (rsp0_valid !== 1'b0) begin errors++;
            $display("FAIL single_rsp_clear: got %b expected 0", rsp0_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_compare();
        bit g, r;
        rsp1_ready = 1'b1;
        run_req(1, 4'b0110, 32'h1234, 32'h1234, g);
        wait_rsp(1, r);
        checks++; if (!g || !r) begin errors++;
            $display("FAIL cmp_eq_timeout: got grant=%b rsp=%b expected 1 1", g, r); end
        checks++; if (rsp_zero !== 1'b1 || rsp_result !== 32'd0 || rsp0_valid !== 1'b0) begin errors++;
            $display("FAIL cmp_eq: got %h %b rsp0=%b expected 0 1 0", rsp_result, rsp_zero, rsp0_valid); end
        @(posedge clk); #1;
        run_req(1, 4'b0110, 32'd9, 32'd4, g);
        wait_rsp(1, r);
        checks++; if (!g || !r || rsp_result !== 32'd5 || rsp_zero !== 1'b0) begin errors++;
            $display("FAIL cmp_ne: got %h %b expected 5 0", rsp_result, rsp_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_collision();
        int ng;
        int exp_g;
        int got_g;
        apply_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_op = 4'b0000; req0_a = 32'hF0; req0_b = 32'h3C;
        req1_op = 4'b0001; req1_a = 32'hF0; req1_b = 32'h3C;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                exp_g = 0;
`ifdef ALU_ARB_RR_EN
                exp_g = ng % 2;
`endif
                got_g = req1_ready ? 1 : 0;
                checks++; if ((req0_ready && req1_ready) || got_g != exp_g) begin errors++;
                    $display("FAIL collision_grant%0d: got %b%b expected winner %0d", ng, req0_ready, req1_ready, exp_g); end
                ng++;
            end
            if (rsp0_valid) begin
                checks++; if (rsp_result !== 32'h30) begin errors++;
                    $display("FAIL collision_rsp0: got %h expected 30", rsp_result); end
            end
            if (rsp1_valid) begin
                checks++; if (rsp_result !== 32'hFC) begin errors++;
                    $display("FAIL collision_rsp1: got %h expected fc", rsp_result); end
            end
            @(posedge clk); #1;
        end
        checks++; if (ng != 4) begin errors++;
            $display("FAIL collision_count: got %0d grants expected 4", ng); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_backpressure();
        bit g, r, seen1;
        int hs;
        int grant_cyc;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        run_req(0, 4'b0010, 32'd100, 32'd23, g);
        wait_rsp(0, r);
        checks++; if (!g || !r || rsp_result !== 32'd123) begin errors++;
            $display("FAIL bp_first: got %h grant=%b rsp=%b expected 7b 1 1", rsp_result, g, r); end
        @(posedge clk); #1;
        req1_op = 4'b0001; req1_a = 32'd1; req1_b = 32'd2; req1_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (rsp0_valid !== 1'b1 || rsp_result !== 32'd123 || alu_a !== 32'd100 ||
                alu_b !== 32'd23 || alu_control !== 4'b0010 || req0_ready !== 1'b0 ||
                req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b res=%h a=%h b=%h op=%h rdy=%b%b expected 1 7b 64 17 2 00",
                         c, rsp0_valid, rsp_result, alu_a, alu_b, alu_control, req0_ready, req1_ready);
            end
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b1;
        hs = 0;
        seen1 = 1'b0;
        grant_cyc = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp0_valid && rsp0_ready) hs++;
            if (req1_ready && !seen1) begin seen1 = 1'b1; grant_cyc = c; end
            if (rsp1_valid) begin
                checks++; if (rsp_result !== 32'd3) begin errors++;
                    $display("FAIL bp_rsp1: got %h expected 3", rsp_result); end
            end
            @(posedge clk); #1;
            if (seen1) req1_valid = 1'b0;
        end
        checks++; if (hs != 1) begin errors++;
            $display("FAIL bp_handshakes: got %0d expected 1", hs); end
        checks++; if (grant_cyc != 1) begin errors++;
            $display("FAIL bp_next_grant: got cycle %0d expected 1", grant_cyc); end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit g, r;
        int stale;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        run_req(0, 4'b0010, 32'h11, 32'h22, g);
        checks++; if (!g || alu_a !== 32'h11) begin errors++;
            $display("FAIL rmid_grant: got grant=%b a=%h expected 1 11", g, alu_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++;
            $display("FAIL rmid_handshake: got %b%b%b%b expected 0000", req0_ready, req1_ready, rsp0_valid, rsp1_valid); end
        checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 4'd0 || rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin errors++;
            $display("FAIL rmid_regs: got %h %h %h %h %b expected all 0", alu_a, alu_b, alu_control, rsp_result, rsp_zero); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) stale++;
        end
        checks++; if (stale != 0) begin errors++;
            $display("FAIL rmid_stale: got %0d valid cycles expected 0", stale); end
        @(posedge clk); #1;
        run_req(1, 4'b0001, 32'hF0, 32'h0F, g);
        wait_rsp(1, r);
        checks++; if (!g || !r || rsp_result !== 32'hFF || rsp_zero !== 1'b0) begin errors++;
            $display("FAIL rmid_after: got %h %b expected ff 0", rsp_result, rsp_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_default_op();
        bit g, r;
        rsp0_ready = 1'b1;
        run_req(0, 4'b1111, 32'hDEADBEEF, 32'h1, g);
        wait_rsp(0, r);
        checks++; if (!g || !r || rsp_result !== 32'hDEADBEEF || rsp_zero !== 1'b0) begin errors++;
            $display("FAIL default_op: got %h %b expected deadbeef 0", rsp_result, rsp_zero); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_compare();
        test_collision();
        test_backpressure();
        test_reset_mid();
        test_default_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
